// File: rtl/uart_pkg.sv
// Shared definitions for the UART transmit path: arbiter states, owner codes
// and the default byte driven while nobody owns the channel.
package uart_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_HOLD = 2'd1,
    ST_GAP  = 2'd2
  } arb_state_e;

  localparam logic [1:0] OWNER_NONE = 2'd0;
  localparam logic [1:0] OWNER_GS   = 2'd1;
  localparam logic [1:0] OWNER_SC   = 2'd2;
  localparam logic [1:0] OWNER_MN   = 2'd3;

  localparam logic [7:0] IDLE_BYTE_DEFAULT = 8'h00;

  // Completion pulse pattern for an owner, ordered {gs, sc, mn}.
  function automatic logic [2:0] owner_done_mask(input logic [1:0] who);
    logic [2:0] mask;
    mask = 3'b000;
    case (who)
      OWNER_GS: mask = 3'b100;
      OWNER_SC: mask = 3'b010;
      OWNER_MN: mask = 3'b001;
      default:  mask = 3'b000;
    endcase
    return mask;
  endfunction

endpackage

// File: rtl/rr_pick2.sv
// Two-way round-robin chooser; the last-served flag only moves when the
// caller reports a completed transfer.
module rr_pick2 (
  input  logic clock,
  input  logic reset_n,
  input  logic req_a_i,
  input  logic req_b_i,
  input  logic update_i,
  input  logic served_b_i,
  output logic grant_a_o,
  output logic grant_b_o
);

  logic last_b_q;
  logic last_b_d;

  // Side A wins a tie whenever side B was served last.
  always_comb begin
    grant_a_o = req_a_i && (!req_b_i || last_b_q);
    grant_b_o = req_b_i && !grant_a_o;
  end

  always_comb begin
    last_b_d = last_b_q;
    if (update_i) begin
      last_b_d = served_b_i;
    end
  end

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      last_b_q <= 1'b1;
    end else begin
      last_b_q <= last_b_d;
    end
  end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Shares the UART transmit byte channel among game-state, script-executor and
// manual requesters: one byte at a time, held until sent, then a guard gap.
module uart_tx_arbiter
  import uart_pkg::*;
#(
  parameter int         GAP_CYCLES     = 16,
  parameter int         TIMEOUT_CYCLES = 4096,
  parameter logic [7:0] IDLE_BYTE      = IDLE_BYTE_DEFAULT
) (
  input  logic       clock,
  input  logic       reset_n,
  input  logic       script_mode,
  input  logic       gs_req,
  input  logic [7:0] gs_bits,
  input  logic       sc_req,
  input  logic [7:0] sc_bits,
  input  logic       mn_req,
  input  logic [7:0] mn_bits,
  input  logic       tx_ready,
  output logic [7:0] tx_bits,
  output logic       gs_done,
  output logic       sc_done,
  output logic       mn_done,
  output logic       busy,
  output logic       timeout_err,
  output logic [1:0] owner
);

  localparam int TW = $clog2(TIMEOUT_CYCLES) + 1;
  localparam int GW = $clog2(GAP_CYCLES) + 1;
  localparam logic [TW-1:0] TIMER_LAST = TW'(TIMEOUT_CYCLES - 1);
  // A zero-length gap still spends one cycle in GAP before returning to IDLE.
  localparam logic [GW-1:0] GAP_LOAD = (GAP_CYCLES > 0) ? GW'(GAP_CYCLES - 1) : '0;

  arb_state_e    state_q;
  logic [7:0]    tx_bits_q;
  logic [1:0]    owner_q;
  logic          busy_q;
  logic          timeout_err_q;
  logic [2:0]    done_q;
  logic [TW-1:0] timer_q;
  logic [GW-1:0] gap_q;

  logic       sc_win;
  logic       mn_win;
  logic       rr_update;
  logic       rr_served_mn;
  logic [1:0] grant_owner;
  logic [7:0] grant_bits;

  assign rr_update    = (state_q == ST_HOLD) && tx_ready &&
                        ((owner_q == OWNER_SC) || (owner_q == OWNER_MN));
  assign rr_served_mn = (owner_q == OWNER_MN);

  rr_pick2 u_rr (
    .clock      (clock),
    .reset_n    (reset_n),
    .req_a_i    (sc_req),
    .req_b_i    (mn_req),
    .update_i   (rr_update),
    .served_b_i (rr_served_mn),
    .grant_a_o  (sc_win),
    .grant_b_o  (mn_win)
  );

  // Game-state traffic always pre-empts the round-robin pair.
  always_comb begin
    grant_owner = OWNER_NONE;
    grant_bits  = IDLE_BYTE;
    if (gs_req) begin
      grant_owner = OWNER_GS;
      grant_bits  = gs_bits;
    end else if (sc_win) begin
      grant_owner = OWNER_SC;
      grant_bits  = sc_bits;
    end else if (mn_win) begin
      grant_owner = OWNER_MN;
      grant_bits  = mn_bits;
    end
  end

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      state_q       <= ST_IDLE;
      tx_bits_q     <= IDLE_BYTE;
      owner_q       <= OWNER_NONE;
      busy_q        <= 1'b0;
      timeout_err_q <= 1'b0;
      done_q        <= 3'b000;
      timer_q       <= '0;
      gap_q         <= '0;
    end else begin
      done_q <= 3'b000;
      case (state_q)
        ST_IDLE: begin
          if (!script_mode && (grant_owner != OWNER_NONE)) begin
            state_q   <= ST_HOLD;
            owner_q   <= grant_owner;
            tx_bits_q <= grant_bits;
            timer_q   <= '0;
            busy_q    <= 1'b1;
          end
        end
        ST_HOLD: begin
          // A ready pulse on the expiry cycle still counts as a delivered byte.
          if (tx_ready || (timer_q == TIMER_LAST)) begin
            if (tx_ready) begin
              done_q <= owner_done_mask(owner_q);
            end else begin
              timeout_err_q <= 1'b1;
            end
            state_q   <= ST_GAP;
            gap_q     <= GAP_LOAD;
            owner_q   <= OWNER_NONE;
            tx_bits_q <= IDLE_BYTE;
          end else begin
            timer_q <= timer_q + TW'(1);
          end
        end
        ST_GAP: begin
          if (gap_q == '0) begin
            state_q <= ST_IDLE;
            busy_q  <= 1'b0;
          end else begin
            gap_q <= gap_q - GW'(1);
          end
        end
        default: begin
          state_q   <= ST_IDLE;
          owner_q   <= OWNER_NONE;
          tx_bits_q <= IDLE_BYTE;
          busy_q    <= 1'b0;
        end
      endcase
    end
  end

  assign tx_bits     = tx_bits_q;
  assign owner       = owner_q;
  assign busy        = busy_q;
  assign timeout_err = timeout_err_q;
  assign gs_done     = done_q[2];
  assign sc_done     = done_q[1];
  assign mn_done     = done_q[0];

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Bench for uart_tx_arbiter: a vector table, directed corner sequences and a
// random phase, all checked against a timestamp-based reference model.
module tb_uart_tx_arbiter;

  localparam int         GAP    = 16;
  localparam int         TMO    = 64;
  localparam logic [7:0] IDLEB  = 8'h00;
  localparam int         GAPLEN = (GAP > 0) ? GAP : 1;

  logic       clock = 1'b0;
  logic       reset_n = 1'b0;
  logic       script_mode = 1'b0;
  logic       gs_req = 1'b0;
  logic       sc_req = 1'b0;
  logic       mn_req = 1'b0;
  logic       tx_ready = 1'b0;
  logic [7:0] gs_bits = 8'h00;
  logic [7:0] sc_bits = 8'h00;
  logic [7:0] mn_bits = 8'h00;
  logic [7:0] tx_bits;
  logic       gs_done;
  logic       sc_done;
  logic       mn_done;
  logic       busy;
  logic       timeout_err;
  logic [1:0] owner;

  int total = 0;
  int bad = 0;

  uart_tx_arbiter #(
    .GAP_CYCLES     (GAP),
    .TIMEOUT_CYCLES (TMO),
    .IDLE_BYTE      (IDLEB)
  ) dut (
    .clock       (clock),
    .reset_n     (reset_n),
    .script_mode (script_mode),
    .gs_req      (gs_req),
    .gs_bits     (gs_bits),
    .sc_req      (sc_req),
    .sc_bits     (sc_bits),
    .mn_req      (mn_req),
    .mn_bits     (mn_bits),
    .tx_ready    (tx_ready),
    .tx_bits     (tx_bits),
    .gs_done     (gs_done),
    .sc_done     (sc_done),
    .mn_done     (mn_done),
    .busy        (busy),
    .timeout_err (timeout_err),
    .owner       (owner)
  );

  always #5 clock = ~clock;

  // Reference model: ownership plus the edge numbers at which the byte was
  // granted and at which the channel may grant again.
  int         cyc = 0;
  bit         mOwned = 1'b0;
  logic [1:0] mOwner = 2'd0;
  logic [7:0] mBits = IDLEB;
  int         mGrantAt = 0;
  int         mIdleAt = 0;
  bit         mLastMn = 1'b1;
  bit         mErr = 1'b0;
  logic [2:0] mDone = 3'b000;

  task automatic modelGrant(input logic [1:0] who, input logic [7:0] b);
    mOwned   = 1'b1;
    mOwner   = who;
    mBits    = b;
    mGrantAt = cyc;
  endtask

  task automatic modelEdge();
    cyc++;
    mDone = 3'b000;
    if (!reset_n) begin
      mOwned  = 1'b0;
      mOwner  = 2'd0;
      mBits   = IDLEB;
      mIdleAt = 0;
      mLastMn = 1'b1;
      mErr    = 1'b0;
    end else if (mOwned) begin
      if (tx_ready) begin
        if (mOwner == 2'd1) mDone = 3'b100;
        if (mOwner == 2'd2) begin mDone = 3'b010; mLastMn = 1'b0; end
        if (mOwner == 2'd3) begin mDone = 3'b001; mLastMn = 1'b1; end
        mOwned  = 1'b0;
        mIdleAt = cyc + GAPLEN + 1;
      end else if (cyc - mGrantAt == TMO) begin
        mErr    = 1'b1;
        mOwned  = 1'b0;
        mIdleAt = cyc + GAPLEN + 1;
      end
    end else if (cyc >= mIdleAt && !script_mode) begin
      if (gs_req) modelGrant(2'd1, gs_bits);
      else if (sc_req && (!mn_req || mLastMn)) modelGrant(2'd2, sc_bits);
      else if (mn_req) modelGrant(2'd3, mn_bits);
    end
  endtask

  function automatic logic [14:0] expected();
    logic [7:0] t;
    logic [1:0] o;
    logic       bz;
    t  = mOwned ? mBits : IDLEB;
    o  = mOwned ? mOwner : 2'd0;
    bz = mOwned || (cyc + 1 < mIdleAt);
    return {t, o, bz, mErr, mDone};
  endfunction

  task automatic checkOutput(input string tag);
    logic [14:0] act;
    logic [14:0] exp;
    act = {tx_bits, owner, busy, timeout_err, gs_done, sc_done, mn_done};
    exp = expected();
    total++;
    if (act !== exp) begin
      bad++;
      $display("[TB] FAIL %s cyc=%0d got tx=%h owner=%0d busy=%b err=%b done(gs,sc,mn)=%b want tx=%h owner=%0d busy=%b err=%b done(gs,sc,mn)=%b",
               tag, cyc, act[14:7], act[6:5], act[4], act[3], act[2:0],
               exp[14:7], exp[6:5], exp[4], exp[3], exp[2:0]);
    end
  endtask

  task automatic checkValue(input string tag, input int got, input int want);
    total++;
    if (got !== want) begin
      bad++;
      $display("[TB] FAIL %s got=%0d want=%0d", tag, got, want);
    end
  endtask

  task automatic step(input string tag);
    @(posedge clock);
    modelEdge();
    #1;
    checkOutput(tag);
  endtask

  task automatic applyStimulus(input logic rstN, input logic scr,
                               input logic gR, input logic [7:0] gB,
                               input logic sR, input logic [7:0] sB,
                               input logic mR, input logic [7:0] mB,
                               input logic txr);
    reset_n = rstN; script_mode = scr;
    gs_req = gR; gs_bits = gB;
    sc_req = sR; sc_bits = sB;
    mn_req = mR; mn_bits = mB;
    tx_ready = txr;
  endtask

  task automatic waitGrant(input string tag, input int limit);
    int n;
    n = 0;
    while (!mOwned && n < limit) begin
      step(tag);
      n++;
    end
    if (!mOwned) begin
      total++;
      bad++;
      $display("[TB] FAIL %s no grant within %0d cycles", tag, limit);
    end
  endtask

  task automatic waitIdle(input string tag, input int limit);
    int n;
    n = 0;
    while ((mOwned || cyc + 1 < mIdleAt) && n < limit) begin
      step(tag);
      n++;
    end
    if (mOwned || cyc + 1 < mIdleAt) begin
      total++;
      bad++;
      $display("[TB] FAIL %s channel still busy after %0d cycles", tag, limit);
    end
  endtask

  typedef struct {
    logic       rstN;
    logic       scr;
    logic       mnR;
    logic [7:0] mnB;
    logic       txr;
    logic [7:0] expTx;
    logic [1:0] expOwn;
    logic       expBusy;
    logic       expMnDone;
  } vec_t;

  vec_t vecs[9];
  int   order[5] = '{1, 2, 3, 2, 3};

  initial begin
    #1000000;
    $display("[TB] FAIL watchdog expired at cyc=%0d", cyc);
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    int cnt;
    int doneCnt;
    int gapCnt;

    // script_mode blocks, release grants next edge, dropped request still completes,
    // and a ready pulse during GAP is ignored.
    vecs[0] = '{1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 8'h00, 2'd0, 1'b0, 1'b0};
    vecs[1] = '{1'b1, 1'b1, 1'b1, 8'h5A, 1'b0, 8'h00, 2'd0, 1'b0, 1'b0};
    vecs[2] = '{1'b1, 1'b1, 1'b1, 8'h5A, 1'b0, 8'h00, 2'd0, 1'b0, 1'b0};
    vecs[3] = '{1'b1, 1'b0, 1'b1, 8'h5A, 1'b0, 8'h5A, 2'd3, 1'b1, 1'b0};
    vecs[4] = '{1'b1, 1'b0, 1'b1, 8'h5A, 1'b0, 8'h5A, 2'd3, 1'b1, 1'b0};
    vecs[5] = '{1'b1, 1'b0, 1'b0, 8'h5A, 1'b1, 8'h00, 2'd0, 1'b1, 1'b1};
    vecs[6] = '{1'b1, 1'b0, 1'b0, 8'h00, 1'b0, 8'h00, 2'd0, 1'b1, 1'b0};
    vecs[7] = '{1'b1, 1'b0, 1'b0, 8'h00, 1'b1, 8'h00, 2'd0, 1'b1, 1'b0};
    vecs[8] = '{1'b1, 1'b0, 1'b0, 8'h00, 1'b0, 8'h00, 2'd0, 1'b1, 1'b0};

    applyStimulus(1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 8'h00, 1'b0, 8'h00, 1'b0);
    repeat (3) step("reset state");

    for (int i = 0; i < 9; i++) begin
      applyStimulus(vecs[i].rstN, vecs[i].scr, 1'b0, 8'h00, 1'b0, 8'h00,
                    vecs[i].mnR, vecs[i].mnB, vecs[i].txr);
      step("table model");
      total++;
      if ({tx_bits, owner, busy, mn_done} !==
          {vecs[i].expTx, vecs[i].expOwn, vecs[i].expBusy, vecs[i].expMnDone}) begin
        bad++;
        $display("[TB] FAIL table row %0d got tx=%h owner=%0d busy=%b mn_done=%b want tx=%h owner=%0d busy=%b mn_done=%b",
                 i, tx_bits, owner, busy, mn_done,
                 vecs[i].expTx, vecs[i].expOwn, vecs[i].expBusy, vecs[i].expMnDone);
      end
    end
    applyStimulus(1'b1, 1'b0, 1'b0, 8'h00, 1'b0, 8'h00, 1'b0, 8'h00, 1'b0);
    waitIdle("table drain", 40);

    // Single manual byte answered 40 cycles after grant.
    applyStimulus(1'b1, 1'b0, 1'b0, 8'h00, 1'b0, 8'h00, 1'b1, 8'h25, 1'b0);
    waitGrant("mn grant", 10);
    cnt = 0;
    if (tx_bits == 8'h25) cnt++;
    repeat (39) begin
      step("mn hold");
      if (tx_bits == 8'h25) cnt++;
    end
    checkValue("mn hold cycles", cnt, 40);
    tx_ready = 1'b1;
    step("mn ready");
    doneCnt = int'(mn_done);
    gapCnt = 0;
    if (busy && tx_bits == IDLEB) gapCnt++;
    tx_ready = 1'b0;
    mn_req = 1'b0;
    repeat (16) begin
      step("mn gap");
      doneCnt += int'(mn_done);
      if (busy && tx_bits == IDLEB) gapCnt++;
    end
    checkValue("mn done pulses", doneCnt, 1);
    checkValue("mn gap cycles", gapCnt, 16);
    checkValue("mn idle after gap", int'(busy), 0);

    // All three at once: gs first, then sc and mn alternate.
    applyStimulus(1'b1, 1'b0, 1'b1, 8'hA1, 1'b1, 8'hB2, 1'b1, 8'hC3, 1'b0);
    for (int k = 0; k < 5; k++) begin
      waitGrant("allreq grant", 40);
      checkValue("allreq order", int'(owner), order[k]);
      repeat (9) step("allreq hold");
      tx_ready = 1'b1;
      step("allreq ready");
      tx_ready = 1'b0;
      if (order[k] == 1) gs_req = 1'b0;
    end
    applyStimulus(1'b1, 1'b0, 1'b0, 8'h00, 1'b0, 8'h00, 1'b0, 8'h00, 1'b0);
    waitIdle("allreq drain", 40);

    // Timeout: no ready for the whole HOLD window, then another requester is served.
    mn_req = 1'b1;
    mn_bits = 8'h77;
    waitGrant("tmo grant", 10);
    repeat (TMO - 1) step("tmo hold");
    checkValue("tmo err before expiry", int'(timeout_err), 0);
    step("tmo expiry");
    checkValue("tmo err set", int'(timeout_err), 1);
    checkValue("tmo no done", int'(mn_done), 0);
    mn_req = 1'b0;
    sc_req = 1'b1;
    sc_bits = 8'h5C;
    waitGrant("post tmo grant", 40);
    checkValue("post tmo owner", int'(owner), 2);
    tx_ready = 1'b1;
    step("post tmo ready");
    tx_ready = 1'b0;
    sc_req = 1'b0;
    checkValue("post tmo sc done", int'(sc_done), 1);
    checkValue("tmo err sticky", int'(timeout_err), 1);
    waitIdle("post tmo drain", 40);

    // Reset in the middle of HOLD, stray ready 5 cycles after release.
    mn_req = 1'b1;
    mn_bits = 8'h3C;
    waitGrant("rst grant", 10);
    repeat (5) step("rst hold");
    reset_n = 1'b0;
    mn_req = 1'b0;
    step("rst assert");
    checkValue("rst tx idle", int'(tx_bits), 0);
    checkValue("rst owner none", int'(owner), 0);
    reset_n = 1'b1;
    repeat (4) step("rst release");
    tx_ready = 1'b1;
    step("rst stray ready");
    tx_ready = 1'b0;
    checkValue("rst stray no done", int'(mn_done), 0);
    checkValue("rst stray not busy", int'(busy), 0);
    checkValue("rst err cleared", int'(timeout_err), 0);

    // Ready on the exact expiry cycle: delivered, no error.
    mn_req = 1'b1;
    mn_bits = 8'hE7;
    waitGrant("tie grant", 10);
    repeat (TMO - 1) step("tie hold");
    tx_ready = 1'b1;
    step("tie edge");
    tx_ready = 1'b0;
    mn_req = 1'b0;
    checkValue("tie done", int'(mn_done), 1);
    checkValue("tie no err", int'(timeout_err), 0);
    waitIdle("tie drain", 40);

    // Random traffic against the model.
    for (int i = 0; i < 4000; i++) begin
      step("random");
      if (gs_req) begin
        if (mDone[2]) begin gs_req = 1'($urandom_range(0, 1)); gs_bits = 8'($urandom); end
      end else if ($urandom_range(0, 15) == 0) begin
        gs_req = 1'b1; gs_bits = 8'($urandom);
      end
      if (sc_req) begin
        if (mDone[1]) begin sc_req = 1'($urandom_range(0, 1)); sc_bits = 8'($urandom); end
      end else if ($urandom_range(0, 7) == 0) begin
        sc_req = 1'b1; sc_bits = 8'($urandom);
      end
      if (mn_req) begin
        if (mDone[0]) begin mn_req = 1'($urandom_range(0, 1)); mn_bits = 8'($urandom); end
      end else if ($urandom_range(0, 7) == 0) begin
        mn_req = 1'b1; mn_bits = 8'($urandom);
      end
      tx_ready = ($urandom_range(0, 19) == 0);
      if ($urandom_range(0, 59) == 0) script_mode = ~script_mode;
      reset_n = ($urandom_range(0, 1499) != 0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/uart_tx_arbiter.md
# uart_tx_arbiter

Shares the single UART transmit byte channel among three requesters: game-state changes, the script executor and manual button/switch operations. It sits between those sources and the UART `io_dataIn_bits`/`io_dataIn_ready` pair, on the 16× baud clock. It serialises their bytes one at a time, holds each byte until the UART reports completion, then inserts a guard gap. Transmission is blocked while a script is being loaded.

## Interface
Parameters:
- `GAP_CYCLES`, default 16: idle cycles after each completed byte (one bit time at 16×).
- `TIMEOUT_CYCLES`, default 4096: maximum HOLD duration before the byte is abandoned.
- `IDLE_BYTE`, default 8'h00: value driven on `tx_bits` when no byte is owned.

Ports:
- `clock` in 1: UART 16× clock; the only clock.
- `reset_n` in 1: synchronous, active-low reset.
- `script_mode` in 1: high while ScriptMem loads; blocks new grants.
- `gs_req`, `gs_bits` in 1/8: game-state requester.
- `sc_req`, `sc_bits` in 1/8: script-executor requester.
- `mn_req`, `mn_bits` in 1/8: manual-operation requester.
- `tx_ready` in 1: UART `io_dataIn_ready`; one-cycle pulse when a byte has been sent.
- `tx_bits` out 8: to UART `io_dataIn_bits`.
- `gs_done`, `sc_done`, `mn_done` out 1: one-cycle completion pulse to the owning requester.
- `busy` out 1: high in HOLD or GAP.
- `timeout_err` out 1: sticky; set on timeout, cleared only by reset.
- `owner` out 2: 0 none, 1 gs, 2 sc, 3 mn (debug/LED).

## Operation
- States: IDLE, HOLD, GAP.
- IDLE: `tx_bits` = `IDLE_BYTE`, `owner` = 0. If `script_mode` = 0 and any request is high, pick the winner, latch its bits into `tx_bits`, set `owner`, clear timer, go to HOLD.
- Priority: `gs` always wins. `sc` and `mn` alternate round-robin. The last-served flag is updated only on completion and resets to "mn served", so `sc` wins the first tie.
- HOLD: `tx_bits` is held constant. On `tx_ready`, pulse the owner's done next cycle, load the gap counter with `GAP_CYCLES`-1, go to GAP. If the timer reaches `TIMEOUT_CYCLES`-1 without `tx_ready`: set `timeout_err`, no done pulse, go to GAP.
- GAP: `tx_bits` = `IDLE_BYTE`, `owner` = 0. The counter decrements to 0, then the state goes to IDLE. `GAP_CYCLES` = 0 is legal: GAP lasts one cycle.
- Requests are level, held by the requester until its done. A request dropped during HOLD does not abort: the byte completes and done still pulses.
- A request still high after its done (the same cycle or later) is a new byte.
- `script_mode` rising during HOLD: the current byte completes normally. No new grant occurs while `script_mode` is high.
- `tx_ready` outside HOLD is ignored.
- Counter widths are `$clog2` of the parameter + 1; no wrap is possible.

## Timing
- Reset values: `tx_bits` = `IDLE_BYTE`, all done pulses 0, `busy` 0, `timeout_err` 0, `owner` 0, state IDLE.
- Reset asserted mid-HOLD: returns to IDLE on the next edge, with no done pulse and the latched byte discarded.
- Grant latency: a request sampled in IDLE at edge t appears on `tx_bits`/`owner` after edge t, and `busy` is high from then on.
- Completion: `tx_ready` sampled at edge t gives a done pulse high for the cycle after t.
- Minimum byte period: 1 (grant) + UART time + `GAP_CYCLES` + 1 (return to IDLE).
- The earliest back-to-back grant comes 1 + `GAP_CYCLES` cycles after the done pulse.
- Simultaneous `tx_ready` and timeout expiry: `tx_ready` wins, giving a done pulse and no error.

## Structure
- A shared package (`uart_pkg`) holds the state enum, the `OWNER_*` encodings and the `IDLE_BYTE` default. DemoTop-level constants can reuse it.
- One natural sub-module, `rr_pick2`: a combinational 2-way round-robin chooser with a registered last-served flag, used for `sc`/`mn`.
- Everything else is inline.

## Test plan
- Single `mn_req`, bits 8'h25, with `tx_ready` 40 cycles after grant: `tx_bits` = 8'h25 for those 40 cycles, then `mn_done` pulses once, then `IDLE_BYTE` for 16 cycles.
- `gs`, `sc` and `mn` all requesting simultaneously, each answered after 10 cycles: served in order gs, sc, mn. With `sc`/`mn` held continuously they then alternate sc, mn, sc.
- `script_mode` = 1 with `mn_req` high: no grant, `tx_bits` stays 8'h00. After `script_mode` falls, the grant follows one cycle later.
- `TIMEOUT_CYCLES` = 64 and no `tx_ready`: `timeout_err` sets at cycle 64 of HOLD, with no done pulse. A following request is still served.
- Reset asserted in HOLD, with `tx_ready` arriving 5 cycles after release: IDLE follows, `tx_bits` = 8'h00, no done pulse, and the stray `tx_ready` is ignored.
- `tx_ready` on the same cycle as timeout expiry: done pulses and `timeout_err` stays 0.
